// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 timing constants and reader FSM states
// Purpose : constants for the 800x525 raster, the 320x480 stored image,
//           and the frame reader state encoding.
// Ports   : none (package).
package vga_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int H_FP_END     = 656;
  localparam int H_SYNC_END   = 752;
  localparam int H_TOTAL      = 800;

  localparam int V_ACTIVE     = 480;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 492;
  localparam int V_TOTAL      = 525;

  localparam int IMG_W        = 320;
  localparam int IMG_H        = 480;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_DISPLAY    = 2'd2
  } state_t;

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel enable, h/v raster counters and raw syncs
// Purpose : divides clk by two into a pixel enable and runs the 800x525
//           raster counters; sync/active flags decode the current count.
// Ports   : i_clk, i_rst     - clock, synchronous active-high reset
//           o_en             - pixel enable (high every other clk)
//           o_h, o_v         - current raster position
//           o_hsync, o_vsync - active-low syncs for the current position
//           o_active         - current position inside 640x480
//           o_frame_end      - current position is the last of the frame
module vga_timing_gen
  import vga_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  output logic       o_en,
  output logic [9:0] o_h,
  output logic [9:0] o_v,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_active,
  output logic       o_frame_end
);

  logic       r_en;
  logic [9:0] r_h;
  logic [9:0] r_v;
  logic       w_h_last;
  logic       w_v_last;

  assign w_h_last = (r_h == 10'(H_TOTAL - 1));
  assign w_v_last = (r_v == 10'(V_TOTAL - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_en <= 1'b0;
      r_h  <= '0;
      r_v  <= '0;
    end else begin
      r_en <= ~r_en;
      if (r_en) begin
        if (w_h_last) begin
          r_h <= '0;
          r_v <= w_v_last ? 10'd0 : r_v + 10'd1;
        end else begin
          r_h <= r_h + 10'd1;
        end
      end
    end
  end

  assign o_en        = r_en;
  assign o_h         = r_h;
  assign o_v         = r_v;
  assign o_hsync     = ~((r_h >= 10'(H_FP_END)) && (r_h < 10'(H_SYNC_END)));
  assign o_vsync     = ~((r_v >= 10'(V_SYNC_START)) && (r_v < 10'(V_SYNC_END)));
  assign o_active    = (r_h < 10'(H_ACTIVE)) && (r_v < 10'(V_ACTIVE));
  assign o_frame_end = w_h_last && w_v_last;

endmodule

// File: rtl/vga_frame_reader.sv
// rtl/vga_frame_reader.sv - streams a 320x480 grayscale image onto a 640x480 VGA raster
// Purpose : generates pixel memory addresses, gates display on whole frames
//           via a small FSM, and registers colour and syncs together.
// Ports   : i_clk, i_rst          - clock, synchronous active-high reset
//           i_done640             - pixel memory loaded (level)
//           i_pixel               - memory data for o_address (combinational)
//           o_address             - pixel memory address
//           o_vga_clk             - pixel clock (= pixel enable)
//           o_hsync, o_vsync      - active-low syncs, aligned with colour
//           o_blank_n, o_sync_n   - DAC blank (high in active area), sync tied 0
//           o_red/o_green/o_blue  - grayscale colour
//           o_frame_start         - one-clk pulse as a displayed frame begins
module vga_frame_reader
  import vga_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_done640,
  input  logic [7:0]  i_pixel,
  output logic [17:0] o_address,
  output logic        o_vga_clk,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_blank_n,
  output logic        o_sync_n,
  output logic [7:0]  o_red,
  output logic [7:0]  o_green,
  output logic [7:0]  o_blue,
  output logic        o_frame_start
);

  logic        w_en;
  logic [9:0]  w_h;
  logic [9:0]  w_v;
  logic        w_hsync;
  logic        w_vsync;
  logic        w_active;
  logic        w_frame_end;
  logic        w_in_image;
  logic [17:0] w_v_ext;
  logic [17:0] w_img_addr;

  state_t      r_state;
  logic [7:0]  r_rgb;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_blank_n;
  logic        r_frame_start;

  vga_timing_gen u_timing (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .o_en        (w_en),
    .o_h         (w_h),
    .o_v         (w_v),
    .o_hsync     (w_hsync),
    .o_vsync     (w_vsync),
    .o_active    (w_active),
    .o_frame_end (w_frame_end)
  );

  // v*320 + h as shift-add; v <= 479 keeps the sum within 18 bits.
  assign w_in_image = (w_h < 10'(IMG_W)) && (w_v < 10'(IMG_H));
  assign w_v_ext    = {8'd0, w_v};
  assign w_img_addr = (w_v_ext << 8) + (w_v_ext << 6) + {8'd0, w_h};
  assign o_address  = w_in_image ? w_img_addr : 18'd0;

  // Everything below samples the position that is current at the enable
  // edge, so colour and syncs leave together one pixel period later.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_rgb         <= 8'd0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_blank_n     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      if (w_en) begin
        r_frame_start <= (r_state == ST_DISPLAY) && (w_h == 10'd0) && (w_v == 10'd0);
        r_rgb         <= ((r_state == ST_DISPLAY) && w_in_image) ? i_pixel : 8'd0;
        r_hsync       <= w_hsync;
        r_vsync       <= w_vsync;
        r_blank_n     <= w_active;
        case (r_state)
          ST_IDLE:       if (i_done640)   r_state <= ST_WAIT_FRAME;
          // Entering DISPLAY only on the last raster position means a
          // late i_done640 never shows a partial frame.
          ST_WAIT_FRAME: if (w_frame_end) r_state <= ST_DISPLAY;
          ST_DISPLAY:    if (!i_done640)  r_state <= ST_IDLE;
          default:                        r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_vga_clk     = w_en;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_blank_n     = r_blank_n;
  assign o_sync_n      = 1'b0;
  assign o_red         = r_rgb;
  assign o_green       = r_rgb;
  assign o_blue        = r_rgb;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb/tb_vga_frame_reader.sv - self-checking bench for vga_frame_reader
module tb_vga_frame_reader;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        done640 = 1'b0;
  logic [7:0]  pixel;
  logic [17:0] address;
  logic        vga_clk, hsync, vsync, blank_n, sync_n, frame_start;
  logic [7:0]  red, green, blue;

  always #10 clk = ~clk;

  // Pixel memory model: data is the low byte of the address.
  assign pixel = address[7:0];

  vga_frame_reader dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_done640     (done640),
    .i_pixel       (pixel),
    .o_address     (address),
    .o_vga_clk     (vga_clk),
    .o_hsync       (hsync),
    .o_vsync       (vsync),
    .o_blank_n     (blank_n),
    .o_sync_n      (sync_n),
    .o_red         (red),
    .o_green       (green),
    .o_blue        (blue),
    .o_frame_start (frame_start)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
    logic       blank;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    int v;
    int h;
    int addr;
    int rgb;
    int blank;
  } vec_t;
  vec_t tbl[11];

  // Reference model of the raster and reader FSM
  bit     en_m;
  int     h_m, v_m;
  state_t st_m;
  bit     fs_exp;
  int     fs_seen;
  logic [9:0] frc_h, frc_v;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (v=%0d h=%0d)", name, act, exp, v_m, h_m);
    end
  endtask

  function automatic int model_addr(int h, int v);
    return (h < 320 && v < 480) ? v * 320 + h : 0;
  endfunction

  // One clk: push the expected outputs before an enable edge, pop and
  // compare them after it.
  task automatic tick(output bit was_en);
    exp_t e;
    bit   en_edge;
    en_edge = en_m && !rst;
    if (en_edge) begin
      chk("address", int'(address), model_addr(h_m, v_m));
      e.rgb   = (st_m == ST_DISPLAY && h_m < 320 && v_m < 480) ? 8'(model_addr(h_m, v_m)) : 8'd0;
      e.hs    = !(h_m >= 656 && h_m < 752);
      e.vs    = !(v_m >= 490 && v_m < 492);
      e.blank = (h_m < 640 && v_m < 480);
      sb_q.push_back(e);
    end
    fs_exp = en_edge && st_m == ST_DISPLAY && h_m == 0 && v_m == 0;
    @(posedge clk);
    if (rst) begin
      en_m = 1'b0; h_m = 0; v_m = 0; st_m = ST_IDLE; fs_exp = 1'b0;
      sb_q.delete();
    end else begin
      if (en_edge) begin
        case (st_m)
          ST_IDLE:       if (done640) st_m = ST_WAIT_FRAME;
          ST_WAIT_FRAME: if (h_m == 799 && v_m == 524) st_m = ST_DISPLAY;
          ST_DISPLAY:    if (!done640) st_m = ST_IDLE;
          default:       st_m = ST_IDLE;
        endcase
        if (h_m == 799) begin
          h_m = 0;
          v_m = (v_m == 524) ? 0 : v_m + 1;
        end else begin
          h_m = h_m + 1;
        end
      end
      en_m = !en_m;
    end
    @(negedge clk);
    chk("vga_clk", int'(vga_clk), int'(en_m));
    chk("frame_start", int'(frame_start), int'(fs_exp));
    if (frame_start) fs_seen++;
    if (en_edge) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
        e = sb_q.pop_front();
        chk("red", int'(red), int'(e.rgb));
        chk("green", int'(green), int'(e.rgb));
        chk("blue", int'(blue), int'(e.rgb));
        chk("hsync", int'(hsync), int'(e.hs));
        chk("vsync", int'(vsync), int'(e.vs));
        chk("blank_n", int'(blank_n), int'(e.blank));
      end
    end
    was_en = en_edge;
  endtask

  task automatic run(int n);
    bit w;
    for (int i = 0; i < n; i++) tick(w);
  endtask

  // Move the raster to (v,h) so distant rows are reachable in a short run.
  task automatic jump(int v, int h);
    bit w;
    if (en_m) tick(w);
    frc_h = 10'(h);
    frc_v = 10'(v);
    force dut.u_timing.r_h = frc_h;
    force dut.u_timing.r_v = frc_v;
    h_m = h;
    v_m = v;
    tick(w);
    release dut.u_timing.r_h;
    release dut.u_timing.r_v;
  endtask

  task automatic check_reset(string tag);
    chk({tag, "_address"}, int'(address), 0);
    chk({tag, "_red"}, int'(red), 0);
    chk({tag, "_green"}, int'(green), 0);
    chk({tag, "_blue"}, int'(blue), 0);
    chk({tag, "_hsync"}, int'(hsync), 1);
    chk({tag, "_vsync"}, int'(vsync), 1);
    chk({tag, "_blank_n"}, int'(blank_n), 0);
    chk({tag, "_sync_n"}, int'(sync_n), 0);
    chk({tag, "_frame_start"}, int'(frame_start), 0);
    chk({tag, "_vga_clk"}, int'(vga_clk), 0);
    chk({tag, "_h"}, int'(dut.u_timing.r_h), 0);
    chk({tag, "_v"}, int'(dut.u_timing.r_v), 0);
    chk({tag, "_state"}, int'(dut.r_state), int'(ST_IDLE));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit w;
    int en_cnt, nz, low_cnt, guard;
    int falls[$];
    bit prev_hs;

    tbl[0]  = '{0,   5,   5,      8'h05, 1};
    tbl[1]  = '{240, 0,   76800,  8'h00, 1};
    tbl[2]  = '{479, 319, 153599, 8'hFF, 1};
    tbl[3]  = '{239, 319, 76799,  8'hFF, 1};
    tbl[4]  = '{100, 319, 32319,  8'h3F, 1};
    tbl[5]  = '{1,   1,   321,    8'h41, 1};
    tbl[6]  = '{200, 320, 0,      8'h00, 1};
    tbl[7]  = '{0,   320, 0,      8'h00, 1};
    tbl[8]  = '{479, 639, 0,      8'h00, 1};
    tbl[9]  = '{479, 640, 0,      8'h00, 0};
    tbl[10] = '{480, 0,   0,      8'h00, 0};

    en_m = 1'b0; h_m = 0; v_m = 0; st_m = ST_IDLE; fs_seen = 0;
    frc_h = '0; frc_v = '0;

    // Power-on reset
    rst = 1'b1;
    run(2);
    check_reset("por");
    rst = 1'b0;

    // Done640 low: no colour, hsync period 800 enables
    en_cnt = 0; nz = 0;
    prev_hs = hsync;
    for (int i = 0; i < 6000 && falls.size() < 2; i++) begin
      tick(w);
      if (w) begin
        en_cnt++;
        if (prev_hs && !hsync) falls.push_back(en_cnt);
        prev_hs = hsync;
        if (red != 8'd0 || green != 8'd0 || blue != 8'd0) nz++;
      end
    end
    chk("hsync_falls_seen", falls.size(), 2);
    if (falls.size() == 2) chk("hsync_period", falls[1] - falls[0], 800);
    chk("idle_rgb_nonzero", nz, 0);

    // vsync low for exactly two lines
    jump(488, 0);
    low_cnt = 0;
    for (int i = 0; i < 8000; i++) begin
      tick(w);
      if (w && !vsync) low_cnt++;
    end
    chk("vsync_low_enables", low_cnt, 1600);
    jump(524, 790);
    run(40);
    chk("idle_frame_start_count", fs_seen, 0);

    // Done640 rises mid-frame: nothing shown until the next frame
    jump(100, 0);
    done640 = 1'b1;
    nz = 0;
    for (int i = 0; i < 800; i++) begin
      tick(w);
      if (w && red != 8'd0) nz++;
    end
    chk("midframe_rgb_nonzero", nz, 0);
    chk("midframe_frame_start", fs_seen, 0);
    jump(524, 780);
    fs_seen = 0;
    run(3400);
    chk("frame_start_count", fs_seen, 1);
    chk("display_state", int'(dut.r_state), int'(ST_DISPLAY));

    // Address map and colour at table points
    foreach (tbl[k]) begin
      jump(tbl[k].v, tbl[k].h);
      chk("tbl_address", int'(address), tbl[k].addr);
      tick(w);
      chk("tbl_rgb", int'(red), tbl[k].rgb);
      chk("tbl_blank_n", int'(blank_n), tbl[k].blank);
      run(4);
    end

    // Done640 falls during pixel 10 of row 200
    jump(200, 0);
    guard = 0;
    while (!(h_m == 10 && !en_m) && guard < 100) begin
      tick(w);
      guard++;
    end
    chk("fall_reached_h10", h_m, 10);
    done640 = 1'b0;
    nz = 0;
    for (int i = 0; i < 60; i++) begin
      tick(w);
      if (w && h_m == 11) chk("fall_last_pixel", int'(red), 8'h0A);
      if (w && h_m >= 12 && red != 8'd0) nz++;
    end
    chk("fall_rgb_nonzero", nz, 0);
    chk("fall_state", int'(dut.r_state), int'(ST_IDLE));

    // Reset in the middle of a frame
    done640 = 1'b1;
    run(6);
    jump(300, 400);
    run(3);
    rst = 1'b1;
    run(1);
    check_reset("mid_rst");
    rst = 1'b0;
    run(100);
    chk("post_rst_state", int'(dut.r_state), int'(ST_WAIT_FRAME));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
